// File: rtl/gate_vector_checker.sv
// Stimulus/response checker for the two-input gate set: sweeps {a,b} through
// 00,01,10,11, samples the six gate outputs and compares them with the truth table.
module gate_vector_checker #(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  input  logic [5:0] gate_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] fail_mask,
  output logic       fail_valid,
  output logic [1:0] fail_vector
);

  typedef enum logic [1:0] {IDLE, SETTLE, CHECK, DONE} state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [1:0]       vec;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       expected;
  logic [5:0]       mismatch;

  // Bit order matches gate_out: [0]AND [1]OR [2]XOR [3]NAND [4]NOR [5]XNOR.
  assign expected = {~(vec[1] ^ vec[0]), ~(vec[1] | vec[0]), ~(vec[1] & vec[0]),
                      (vec[1] ^ vec[0]),  (vec[1] | vec[0]),  (vec[1] & vec[0])};
  assign mismatch = gate_out ^ expected;

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (start) state_next = SETTLE;
      SETTLE: if (cnt == CNT_LAST) state_next = CHECK;
      CHECK:  state_next = (vec == 2'd3) ? DONE : SETTLE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec         <= '0;
      cnt         <= '0;
      a           <= 1'b0;
      b           <= 1'b0;
      pass        <= 1'b0;
      fail_mask   <= '0;
      fail_valid  <= 1'b0;
      fail_vector <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            vec         <= '0;
            cnt         <= '0;
            a           <= 1'b0;
            b           <= 1'b0;
            pass        <= 1'b0;
            fail_mask   <= '0;
            fail_valid  <= 1'b0;
            fail_vector <= '0;
          end
        end
        SETTLE: cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        CHECK: begin
          fail_mask <= fail_mask | mismatch;
          if ((mismatch != '0) && !fail_valid) begin
            fail_vector <= vec;
            fail_valid  <= 1'b1;
          end
          if (vec == 2'd3) begin
            a    <= 1'b0;
            b    <= 1'b0;
            // Include this final check, whose mismatch is not yet in fail_mask.
            pass <= ~|(fail_mask | mismatch);
          end else begin
            vec      <= vec + 2'd1;
            {a, b}   <= vec + 2'd1;
            cnt      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_vector_checker.sv
// Directed bench: fault-injectable gate model for a SETTLE_CYCLES=2 checker and
// a registered gate model for a SETTLE_CYCLES=1 checker.
module tb_gate_vector_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start1;
  logic       a, b, a1, b1;
  logic [5:0] gate_out, gate_out1;
  logic       busy, done, pass, fail_valid;
  logic       busy1, done1, pass1, fail_valid1;
  logic [5:0] fail_mask, fail_mask1;
  logic [1:0] fail_vector, fail_vector1;
  int         fault_mode;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gate_vector_checker #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .gate_out(gate_out),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .fail_valid(fail_valid), .fail_vector(fail_vector)
  );

  gate_vector_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .gate_out(gate_out1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_mask(fail_mask1),
    .fail_valid(fail_valid1), .fail_vector(fail_vector1)
  );

  function automatic logic [5:0] ideal(input logic x, input logic y);
    return {~(x ^ y), ~(x | y), ~(x & y), x ^ y, x | y, x & y};
  endfunction

  // Gate model: 0 = correct, 1 = AND stuck at 0, 2 = XOR/XNOR swapped.
  always_comb begin
    logic [5:0] g;
    g = ideal(a, b);
    gate_out = g;
    if (fault_mode == 1) gate_out[0] = 1'b0;
    if (fault_mode == 2) begin
      gate_out[2] = g[5];
      gate_out[5] = g[2];
    end
  end

  // Gates behind a one-cycle register for the SETTLE_CYCLES=1 instance.
  always_ff @(posedge clk) gate_out1 <= ideal(a1, b1);

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulses start, then watches 16 cycles; index i is the cycle after edge k0+i.
  // Optionally stops early at cycle stop_at (stop_at < 0 means run all 16).
  task automatic run_sweep(input bit repulse, input int stop_at,
                           output int done_at, output int done_cnt,
                           output bit ab_ok, output bit busy_ok);
    logic [1:0] exp_ab;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    done_at = -1; done_cnt = 0; ab_ok = 1'b1; busy_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (i == stop_at) break;
      if (repulse) start = (i == 4);
      exp_ab = (i < 12) ? 2'(i / 3) : 2'b00;
      if ({a, b} !== exp_ab) ab_ok = 1'b0;
      if (busy !== (i <= 12)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = i;
      end
    end
    start = 1'b0;
  endtask

  int done_at, done_cnt;
  bit ab_ok, busy_ok;

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; fault_mode = 0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {2'b0, a, b, busy, done, pass, fail_valid}, 8'h00);
    check("reset_mask", {2'b0, fail_mask}, 8'h00);
    check("reset_vec",  {6'b0, fail_vector}, 8'h00);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1) correct gates
    run_sweep(1'b0, -1, done_at, done_cnt, ab_ok, busy_ok);
    check("t1_done_at",  8'(done_at), 8'd12);
    check("t1_done_cnt", 8'(done_cnt), 8'd1);
    check("t1_ab_seq",   {7'b0, ab_ok}, 8'd1);
    check("t1_busy",     {7'b0, busy_ok}, 8'd1);
    check("t1_result",   {fail_valid, pass, fail_mask}, {1'b0, 1'b1, 6'b000000});
    repeat (3) @(negedge clk);
    check("t1_hold_pass", {6'b0, pass, busy}, 8'b10);

    // 2) AND stuck at 0
    fault_mode = 1;
    run_sweep(1'b0, -1, done_at, done_cnt, ab_ok, busy_ok);
    check("t2_result", {fail_valid, pass, fail_mask}, {1'b1, 1'b0, 6'b000001});
    check("t2_vector", {6'b0, fail_vector}, 8'b11);

    // 3) XOR/XNOR swapped: every vector mismatches, first one recorded
    fault_mode = 2;
    run_sweep(1'b0, -1, done_at, done_cnt, ab_ok, busy_ok);
    check("t3_result", {fail_valid, pass, fail_mask}, {1'b1, 1'b0, 6'b100100});
    check("t3_vector", {6'b0, fail_vector}, 8'b00);
    repeat (4) @(negedge clk);
    check("t3_hold", {fail_vector, fail_mask}, {2'b00, 6'b100100});

    // 4) start re-pulsed while busy
    fault_mode = 0;
    run_sweep(1'b1, -1, done_at, done_cnt, ab_ok, busy_ok);
    check("t4_done_at",  8'(done_at), 8'd12);
    check("t4_done_cnt", 8'(done_cnt), 8'd1);
    check("t4_pass",     {7'b0, pass}, 8'd1);

    // 5) async reset during vector 10 with a faulty gate set
    fault_mode = 2;
    run_sweep(1'b0, 7, done_at, done_cnt, ab_ok, busy_ok);
    check("t5_pre_ab",   {6'b0, a, b}, 8'b10);
    check("t5_pre_mask", {2'b0, fail_mask}, 8'b00100100);
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_ctrl", {2'b0, a, b, busy, done, pass, fail_valid}, 8'h00);
    check("t5_rst_data", {fail_vector, fail_mask}, 8'h00);
    @(negedge clk); rst_n = 1'b1;
    fault_mode = 0;
    run_sweep(1'b0, -1, done_at, done_cnt, ab_ok, busy_ok);
    check("t5_after_done", 8'(done_at), 8'd12);
    check("t5_after_res", {fail_valid, pass, fail_mask}, {1'b0, 1'b1, 6'b000000});

    // start held high: retrigger at the first IDLE edge after DONE
    @(negedge clk); start = 1'b1;
    done_at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin done_at = i; break; end
    end
    check("hold_done_seen", {7'b0, done_at >= 0}, 8'd1);
    @(negedge clk);
    check("hold_idle", {6'b0, busy, done}, 8'b00);
    @(negedge clk);
    check("hold_retrig", {6'b0, busy, a | b}, 8'b10);
    start = 1'b0;
    repeat (16) @(negedge clk);

    // 6) registered gates, SETTLE_CYCLES=1: done in the cycle after k0+8
    @(negedge clk); start1 = 1'b1;
    @(posedge clk);
    @(negedge clk); start1 = 1'b0;
    done_at = -1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (done1 === 1'b1) begin done_at = i; break; end
    end
    check("t6_done_at", 8'(done_at), 8'd8);
    check("t6_result", {fail_valid1, pass1, fail_mask1}, {1'b0, 1'b1, 6'b000000});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
